// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential radix-2 restoring divider.
//   state_t  - divider FSM states (IDLE, BUSY, DONE)
//   cnt_w()  - width of the iteration counter for a given dividend width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold DW-1; at least one bit even for the smallest width.
  function automatic int cnt_w(input int dw);
    if (dw <= 2) begin
      return 1;
    end else begin
      return $clog2(dw);
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational iteration of restoring division.
// The partial remainder is shifted left, the next dividend bit enters at the
// bottom, and the divisor is subtracted when it fits.
// Ports:
//   pr      in  VW  partial remainder (always < divisor between steps)
//   bit_in  in  1   next dividend bit, MSB first
//   divisor in  VW  divisor magnitude (non-zero)
//   pr_next out VW  updated partial remainder
//   q_bit   out 1   quotient bit produced by this step
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] pr,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] pr_next,
  output logic          q_bit
);

  // The shifted value needs VW+1 bits so the compare can never overflow.
  logic [VW:0] shifted;

  // Shift, compare against the divisor and conditionally subtract.
  always_comb begin
    shifted = {pr, bit_in};
    if (shifted >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      // Result is below the divisor, so the top bit is always zero.
      pr_next = VW'(shifted - {1'b0, divisor});
    end else begin
      q_bit   = 1'b0;
      pr_next = shifted[VW-1:0];
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle radix-2 restoring divider with valid/ready
// handshakes. One quotient bit is resolved per clock; results are registered
// and held until the consumer accepts them.
// Build option: define DIV_SIGNED_EN for two's-complement operands (magnitudes
// are divided, quotient truncates toward zero, remainder follows the dividend).
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   dividend [DW]      dividend
//   divisor  [VW]      divisor
//   out_valid/out_ready result handshake
//   quotient [DW]      quotient
//   remainder[DW]      remainder, widened to DW
//   div_by_zero        result produced with divisor == 0
module div_seq_param
  import div_pkg::*;
#(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = cnt_w(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  logic [VW-1:0] pr_r;
  logic [DW-1:0] q_sh;

  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW-1:0] step_pr;
  logic          step_q;
  logic [DW-1:0] q_fin;
  logic [DW-1:0] r_fin;
  logic [DW-1:0] q_res;
  logic [DW-1:0] r_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step #(.VW(VW)) u_step (
    .pr      (pr_r),
    .bit_in  (dvd_r[cnt]),
    .divisor (dvs_r),
    .pr_next (step_pr),
    .q_bit   (step_q)
  );

  // Value that will be loaded on the final BUSY cycle.
  assign q_fin = {q_sh[DW-2:0], step_q};
  assign r_fin = DW'(step_pr);

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operand magnitudes taken at acceptance; the unsigned core does the rest.
  always_comb begin
    if (dividend[DW-1]) begin
      dvd_mag = DW'(1'b0) - dividend;
    end else begin
      dvd_mag = dividend;
    end
    if (divisor[VW-1]) begin
      dvs_mag = VW'(1'b0) - divisor;
    end else begin
      dvs_mag = divisor;
    end
  end

  // Restore signs: quotient negative when signs differ, remainder follows
  // the dividend. Most-negative / -1 wraps naturally.
  always_comb begin
    if (neg_q) begin
      q_res = DW'(1'b0) - q_fin;
    end else begin
      q_res = q_fin;
    end
    if (neg_r) begin
      r_res = DW'(1'b0) - r_fin;
    end else begin
      r_res = r_fin;
    end
  end

  // Sign flags captured alongside the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q <= dividend[DW-1] ^ divisor[VW-1];
      neg_r <= dividend[DW-1];
    end else begin
      neg_q <= neg_q;
      neg_r <= neg_r;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_res   = q_fin;
  assign r_res   = r_fin;
`endif

  // FSM, iteration counter, datapath registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      pr_r        <= '0;
      q_sh        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              dvd_r <= dvd_mag;
              dvs_r <= dvs_mag;
              pr_r  <= '0;
              q_sh  <= '0;
              cnt   <= CW'(DW - 1);
              state <= BUSY;
            end else begin
              // Divide by zero skips iteration and reports the raw dividend.
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          pr_r <= step_pr;
          q_sh <= q_fin;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;
  int overlap;

  div_seq_param #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (!rst && in_ready && out_valid) overlap++;
  end

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          hold;
    logic        early;
  } vec_t;

  function automatic vec_t mk(logic [15:0] dvd, logic [7:0] dvs, logic [15:0] q,
                              logic [15:0] r, logic dbz, int hold, logic early);
    vec_t v;
    v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dbz = dbz;
    v.lat = (dvs == 8'd0) ? 1 : 16;
    v.hold = hold; v.early = early;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Wait (bounded) until IDLE, sampled on the falling edge.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait (bounded) for out_valid after a rising edge; returns edges waited.
  task automatic wait_valid(output int lat, output int busy_ready);
    lat = 0;
    busy_ready = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (in_ready) busy_ready++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    int busy_ready;
    int unstable;
    wait_idle(name);
    in_valid  = 1'b1;
    dividend  = v.dvd;
    divisor   = v.dvs;
    out_ready = v.early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'hAA;
    if (!out_valid) begin
      wait_valid(lat, busy_ready);
    end else begin
      lat = 1;
      busy_ready = 0;
    end
    chk({name, "_latency"}, lat, v.lat);
    chk({name, "_busy_in_ready"}, busy_ready, 0);
    chk({name, "_quotient"}, quotient, v.q);
    chk({name, "_remainder"}, remainder, v.r);
    chk({name, "_dbz"}, div_by_zero, v.dbz);
    unstable = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || quotient !== v.q || remainder !== v.r) unstable++;
    end
    if (v.hold > 0) chk({name, "_held"}, unstable, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t vecs[0:10];
  int   nvec;

  initial begin
    int lat;
    int busy_ready;
    int spurious;
    logic [15:0] exp_q1;
    logic [15:0] exp_q2;

    tests = 0;
    fails = 0;
    overlap = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = 16'd0;
    divisor = 8'd0;

    nvec = 0;
    vecs[nvec++] = mk(16'd1000,  8'd7,   16'd142, 16'd6,      1'b0, 0,  1'b1);
    vecs[nvec++] = mk(16'h1234,  8'd0,   16'd0,   16'h1234,   1'b1, 0,  1'b0);
    vecs[nvec++] = mk(16'd10,    8'd3,   16'd3,   16'd1,      1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'd50,    8'd9,   16'd5,   16'd5,      1'b0, 20, 1'b0);
    vecs[nvec++] = mk(16'd0,     8'd5,   16'd0,   16'd0,      1'b0, 0,  1'b1);
    vecs[nvec++] = mk(16'd1234,  8'd1,   16'd1234, 16'd0,     1'b0, 0,  1'b0);
`ifdef DIV_SIGNED_EN
    vecs[nvec++] = mk(16'hFFF9,  8'h02,  16'hFFFD, 16'hFFFF,  1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'h8000,  8'hFF,  16'h8000, 16'h0000,  1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'd7,     8'hFE,  16'hFFFD, 16'd1,     1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'hFFF9,  8'hFE,  16'd3,    16'hFFFF,  1'b0, 0,  1'b0);
    exp_q1 = 16'd1;
    exp_q2 = 16'hFFFF;
`else
    vecs[nvec++] = mk(16'd5,     8'd200, 16'd0,   16'd5,      1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'hFFFF,  8'hFE,  16'd258, 16'd3,      1'b0, 0,  1'b1);
    vecs[nvec++] = mk(16'd40000, 8'd123, 16'd325, 16'd25,     1'b0, 0,  1'b0);
    vecs[nvec++] = mk(16'd255,   8'd255, 16'd1,   16'd0,      1'b0, 0,  1'b0);
    exp_q1 = 16'd257;
    exp_q2 = 16'hFFFF;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 16'd0, 16'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < nvec; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: second operands presented while the first is in flight.
    wait_idle("b2b");
    in_valid = 1'b1;
    dividend = 16'hFFFF;
    divisor = 8'hFF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    dividend = 16'hFFFF;
    divisor = 8'h01;
    wait_valid(lat, busy_ready);
    chk("b2b_first_latency", lat, 16);
    chk("b2b_first_quotient", quotient, exp_q1);
    chk("b2b_first_remainder", remainder, 16'd0);
    chk("b2b_first_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_after_handshake", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_second_accepted", in_ready, 1'b0);
    wait_valid(lat, busy_ready);
    chk("b2b_second_latency", lat, 16);
    chk("b2b_second_quotient", quotient, exp_q2);
    chk("b2b_second_remainder", remainder, 16'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset during BUSY abandons the operation.
    wait_idle("rst_mid");
    in_valid = 1'b1;
    dividend = 16'd500;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_values", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 16'd0, 16'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) spurious++;
    end
    chk("rst_mid_no_result", spurious, 0);
    run_vec("rst_after", mk(16'd500, 8'd3, 16'd166, 16'd2, 1'b0, 0, 1'b0));

    chk("ready_valid_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
